pattern_arb_ctrl: RTL and testbench
===================================

PATTERN_ARB_CTRL -- requirements
Module: pattern_arb_ctrl

Interface
REQ-001 Parameter FRAME_LEN, 8, number of bits in one granted frame (range 1..255).
REQ-002 Parameter DRAIN_CYC, 2, cycles the detector output is still watched after the last bit of a frame (range 1..15).
REQ-003 Parameter CNT_W, 8, width of each per-requester hit counter.
REQ-004 Parameter TIMEOUT_CYC, 16, idle-source abort limit; used only under ARB_TIMEOUT_EN.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 req0_valid / req1_valid  in  1 each  requester has a bit available.
REQ-008 req0_data / req1_data  in  1 each  requester bit (0 = B, 1 = C).
REQ-009 req0_ready / req1_ready  out  1 each  bit accepted when valid and ready are both high.
REQ-010 det_rst  out  1  active-high synchronous reset to the shared pattern detector.
REQ-011 det_valid  out  1  bit-valid to the detector.
REQ-012 det_data  out  1  bit to the detector.
REQ-013 det_pattern  in  1  match flag from the detector.
REQ-014 grant  out  2  one-hot current owner; 2'b00 when no owner.
REQ-015 hit_pulse  out  2  one-cycle pulse on the bit of the requester credited with a match.
REQ-016 hit0_cnt / hit1_cnt  out  CNT_W each  saturating match counts.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, CLEAR, STREAM, DRAIN.
REQ-019 IDLE: with any reqN_valid high, the FSM SHALL pick an owner, load grant, and go to CLEAR on the next edge.
REQ-020 Arbitration SHALL be round-robin per frame. With both valid, the requester that did not own the previous frame wins. After reset, req0 has priority.
REQ-021 CLEAR SHALL last exactly one cycle, drive det_rst=1, and then go to STREAM.
REQ-022 STREAM: ready SHALL be high only for the owner. The non-owner's ready SHALL stay 0 in all states.
REQ-023 A bit accepted in cycle t SHALL appear on det_valid=1 and det_data in cycle t+1 (registered). Otherwise det_valid=0.
REQ-024 A bit counter SHALL count accepted bits. When the FRAME_LEN-th bit is accepted, owner ready SHALL drop and the FSM SHALL go to DRAIN on the next edge.
REQ-025 If the owner's valid is low in STREAM, the FSM SHALL wait, insert no bit, and keep grant.
REQ-026 DRAIN SHALL last exactly DRAIN_CYC cycles, then the FSM SHALL go to IDLE, record last owner, and clear grant.
REQ-027 det_pattern=1 in any STREAM or DRAIN cycle SHALL raise hit_pulse[owner] in the same cycle and increment the owner's counter on that edge.
REQ-028 det_pattern in IDLE or CLEAR SHALL be ignored.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 A requester whose valid rises during another's frame SHALL be served next, with no bit dropped and none duplicated.

Reset
REQ-031 With rst=0 at an edge, the block SHALL enter IDLE with grant=0, ready=0, det_valid=0, det_data=0, hit_pulse=0, both counters=0, busy=0, bit counter=0, and req0 priority.
REQ-032 det_rst SHALL be 1 in every cycle in which rst=0.
REQ-033 Reset mid-frame SHALL abort the frame without crediting any pending match.

Configuration
REQ-034 With ARB_TIMEOUT_EN defined, TIMEOUT_CYC consecutive STREAM cycles with owner valid low SHALL abort the frame and go to DRAIN. Matches during that DRAIN are still credited.
REQ-035 With ARB_TIMEOUT_EN undefined, STREAM SHALL wait indefinitely (REQ-025) and TIMEOUT_CYC SHALL be unused.

Verification
REQ-036 req0 sends 0,0,1,0,1,1,1,1 against a behavioural BBCBC detector -> grant=01, det_rst high for 1 cycle, 8 det_valid pulses, hit0_cnt=1, hit1_cnt=0, busy low after 1+1+8+2 cycles.
REQ-037 req0 and req1 both valid from reset, 3 frames each -> grant order 01,10,01,10,01,10.
REQ-038 Force det_pattern=1 throughout 300 STREAM/DRAIN cycles for req1 with CNT_W=8 -> hit1_cnt stops at 255.
REQ-039 rst=0 after 4 bits of a req1 frame -> next cycle all outputs at reset values, det_rst=1; next frame goes to req0.
REQ-040 Owner drops valid for 20 cycles mid-frame -> with ARB_TIMEOUT_EN, DRAIN entered after 16 idle cycles; without it, grant held and the frame completes when valid returns.

Source files
------------

// File: rtl/pattern_arb_ctrl_if.sv
// Requester handshake bundle for pattern_arb_ctrl.
// master = requester side, slave = arbiter side.
interface pattern_arb_ctrl_if;
  logic req0_valid;
  logic req0_data;
  logic req0_ready;
  logic req1_valid;
  logic req1_data;
  logic req1_ready;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/pattern_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a shared pattern detector.
// Optional idle-owner abort enabled with ARB_TIMEOUT_EN.
module pattern_arb_ctrl #(
  parameter int FRAME_LEN   = 8,
  parameter int DRAIN_CYC   = 2,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  pattern_arb_ctrl_if.slave req,
  output logic             det_rst,
  output logic             det_valid,
  output logic             det_data,
  input  logic             det_pattern,
  output logic [1:0]       grant,
  output logic [1:0]       hit_pulse,
  output logic [CNT_W-1:0] hit0_cnt,
  output logic [CNT_W-1:0] hit1_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE, CLEAR, STREAM, DRAIN
  } state_t;

  state_t     state, state_nx;
  logic [7:0] bit_cnt, bit_cnt_nx;
  logic [3:0] drn_cnt, drn_cnt_nx;
  logic [1:0] grant_nx;
  logic       last_own, last_own_nx;
  logic       own_valid, own_data;
  logic       accept, hit, tmo;

  assign own_valid = grant[1] ? req.req1_valid
                              : req.req0_valid;
  assign own_data  = grant[1] ? req.req1_data
                              : req.req0_data;

  assign req.req0_ready = rst && (state == STREAM)
                          && grant[0];
  assign req.req1_ready = rst && (state == STREAM)
                          && grant[1];

  assign accept = (req.req0_ready || req.req1_ready)
                  && own_valid;
  assign hit = rst && det_pattern
               && (state == STREAM || state == DRAIN);

  assign hit_pulse = hit ? grant : 2'b00;
  assign det_rst   = !rst || (state == CLEAR);
  assign busy      = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst || state != STREAM || own_valid)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 16'd1;
  end

  assign tmo = (state == STREAM) && !own_valid
               && (idle_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    drn_cnt_nx  = drn_cnt;
    grant_nx    = grant;
    last_own_nx = last_own;
    unique case (state)
      IDLE: begin
        if (req.req0_valid || req.req1_valid) begin
          // last_own=1 means req1 had the previous frame
          if (req.req0_valid && req.req1_valid)
            grant_nx = last_own ? 2'b01 : 2'b10;
          else
            grant_nx = req.req1_valid ? 2'b10 : 2'b01;
          bit_cnt_nx = '0;
          state_nx   = CLEAR;
        end
      end
      CLEAR: state_nx = STREAM;
      STREAM: begin
        if (accept) begin
          bit_cnt_nx = bit_cnt + 8'd1;
          if (bit_cnt == 8'(FRAME_LEN - 1)) begin
            state_nx   = DRAIN;
            drn_cnt_nx = '0;
          end
        end else if (tmo) begin
          state_nx   = DRAIN;
          drn_cnt_nx = '0;
        end
      end
      DRAIN: begin
        if (drn_cnt == 4'(DRAIN_CYC - 1)) begin
          state_nx    = IDLE;
          last_own_nx = grant[1];
          grant_nx    = 2'b00;
        end else begin
          drn_cnt_nx = drn_cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      bit_cnt   <= '0;
      drn_cnt   <= '0;
      last_own  <= 1'b1;
      det_valid <= 1'b0;
      det_data  <= 1'b0;
      hit0_cnt  <= '0;
      hit1_cnt  <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      bit_cnt   <= bit_cnt_nx;
      drn_cnt   <= drn_cnt_nx;
      last_own  <= last_own_nx;
      det_valid <= accept;
      det_data  <= accept && own_data;
      if (hit && grant[0] && !(&hit0_cnt))
        hit0_cnt <= hit0_cnt + CNT_W'(1);
      if (hit && grant[1] && !(&hit1_cnt))
        hit1_cnt <= hit1_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_arb_ctrl.sv
// Randomized and directed bench for pattern_arb_ctrl
// against a transaction-level model of the arbiter.
module tb_pattern_arb_ctrl;
  localparam int FL = 8;
  localparam int DC = 2;
  localparam int CW = 8;
  localparam int TO = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pattern_arb_ctrl_if bus ();
  logic          det_rst, det_valid, det_data;
  logic          det_pattern;
  logic [1:0]    grant, hit_pulse;
  logic [CW-1:0] hit0_cnt, hit1_cnt;
  logic          busy;

  pattern_arb_ctrl #(
    .FRAME_LEN(FL), .DRAIN_CYC(DC),
    .CNT_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(bus),
    .det_rst(det_rst), .det_valid(det_valid),
    .det_data(det_data), .det_pattern(det_pattern),
    .grant(grant), .hit_pulse(hit_pulse),
    .hit0_cnt(hit0_cnt), .hit1_cnt(hit1_cnt),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // BBCBC detector: flags one cycle after 0,0,1,0,1
  logic [4:0] hist = '0;
  int         hcnt = 0;
  logic       match = 1'b0;
  int         pat_mode = 0;
  logic       pat_rnd = 1'b0;

  always @(posedge clk) begin
    if (det_rst) begin
      hist  <= '0;
      hcnt  <= 0;
      match <= 1'b0;
    end else if (det_valid) begin
      hist  <= {hist[3:0], det_data};
      if (hcnt < 5) hcnt <= hcnt + 1;
      match <= ({hist[3:0], det_data} == 5'b00101)
               && (hcnt >= 4);
    end else begin
      match <= 1'b0;
    end
  end

  assign det_pattern = (pat_mode == 0) ? match :
                       (pat_mode == 1) ? 1'b1 : pat_rnd;

  // transaction-level model
  int   m_own = -1;
  bit   m_clear = 0;
  bit   m_stream = 0;
  int   m_bits = 0;
  int   m_drain = 0;
  int   m_idle = 0;
  int   m_last = 1;
  bit   m_dv = 0;
  bit   m_dd = 0;
  int   m_cnt [2] = '{0, 0};
  int   order [$];
  bit   chk_en = 0;

  always @(posedge clk) begin
    bit v, d, acc;
    chk_en = 1;
    if (!rst) begin
      m_own = -1; m_clear = 0; m_stream = 0;
      m_bits = 0; m_drain = 0; m_idle = 0;
      m_last = 1; m_dv = 0; m_dd = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      v = (m_own == 1) ? bus.req1_valid : bus.req0_valid;
      d = (m_own == 1) ? bus.req1_data : bus.req0_data;
      acc = m_stream && v;
      if ((m_stream || m_drain > 0) && det_pattern)
        if (m_cnt[m_own] < CMAX) m_cnt[m_own]++;
      m_dv = acc;
      m_dd = acc ? d : 1'b0;
      if (m_own < 0) begin
        if (bus.req0_valid || bus.req1_valid) begin
          if (bus.req0_valid && bus.req1_valid)
            m_own = (m_last == 0) ? 1 : 0;
          else
            m_own = bus.req1_valid ? 1 : 0;
          m_clear = 1; m_bits = 0; m_idle = 0;
          order.push_back(m_own);
        end
      end else if (m_clear) begin
        m_clear = 0; m_stream = 1;
      end else if (m_stream) begin
        if (acc) begin
          m_bits++; m_idle = 0;
          if (m_bits == FL) begin
            m_stream = 0; m_drain = DC;
          end
        end else begin
          m_idle++;
`ifdef ARB_TIMEOUT_EN
          if (m_idle == TO) begin
            m_stream = 0; m_drain = DC;
          end
`endif
        end
      end else begin
        m_drain--;
        if (m_drain == 0) begin
          m_last = m_own; m_own = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg, eh;
    if (chk_en) begin
      eg = (m_own < 0) ? 2'b00 :
           (m_own == 0) ? 2'b01 : 2'b10;
      eh = (rst && (m_stream || m_drain > 0)
            && det_pattern) ? eg : 2'b00;
      chk("grant", grant, eg);
      chk("busy", busy, m_own >= 0);
      chk("det_rst", det_rst, !rst || m_clear);
      chk("ready0", bus.req0_ready,
          rst && m_stream && m_own == 0);
      chk("ready1", bus.req1_ready,
          rst && m_stream && m_own == 1);
      chk("det_valid", det_valid, m_dv);
      if (m_dv) chk("det_data", det_data, m_dd);
      chk("hit_pulse", hit_pulse, eh);
      chk("hit0_cnt", hit0_cnt, m_cnt[0]);
      chk("hit1_cnt", hit1_cnt, m_cnt[1]);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // hold valids until the arbiter is idle, then drop
  task automatic finish_frames;
    int n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("finish_bound", n < 600, 1'b1);
    tick();
  endtask

  task automatic wait_accepts(int k, bit who);
    int n = 0;
    int c = 0;
    while (n < k && c < 100) begin
      @(negedge clk);
      if (who ? (bus.req1_ready && bus.req1_valid)
              : (bus.req0_ready && bus.req0_valid))
        n++;
      c++;
      if (n < k) tick();
    end
    chk("accept_bound", n, k);
  endtask

  initial begin
    logic [7:0] seq;
    int si, rc, dvc, bat, n;
    logic [1:0] g1;
    logic [1:0] dord [$];
    bus.req0_valid = 1'b0; bus.req0_data = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 1'b0;

    // reset values while rst is held low
    tick();
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_det_rst", det_rst, 1'b1);
    chk("rst_hit0", hit0_cnt, 0);

    // single req0 frame 0,0,1,0,1,1,1,1
    seq = 8'b11110100;
    tick();
    rst = 1'b1;
    si = 0; rc = 0; dvc = 0; bat = -1; g1 = 2'b00;
    bus.req0_valid = 1'b1;
    bus.req0_data = seq[0];
    for (int c = 0; c < 16; c++) begin
      bit acc;
      @(negedge clk);
      if (det_rst) rc++;
      if (det_valid) dvc++;
      if (c == 1) g1 = grant;
      if (!busy && bat < 0 && c > 0) bat = c;
      acc = bus.req0_ready && bus.req0_valid;
      tick();
      if (acc) begin
        si++;
        if (si == 8) bus.req0_valid = 1'b0;
        else bus.req0_data = seq[si];
      end
    end
    chk("f1_grant", g1, 2'b01);
    chk("f1_det_rst_cycles", rc, 1);
    chk("f1_det_valid_pulses", dvc, 8);
    chk("f1_hit0", hit0_cnt, 1);
    chk("f1_hit1", hit1_cnt, 0);
    chk("f1_busy_low_cycle", bat, 12);

    // both valid from reset: strict alternation
    do_reset();
    order.delete();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    n = 0;
    while (dord.size() < 6 && n < 200) begin
      bus.req0_data = 1'($urandom);
      bus.req1_data = 1'($urandom);
      @(negedge clk);
      if (det_rst && rst) dord.push_back(grant);
      tick();
      n++;
    end
    chk("rr_bound", dord.size(), 6);
    finish_frames();
    for (int i = 0; i < 6; i++) begin
      chk("rr_dut_order", (i < dord.size()) ? dord[i] : 0,
          (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_model_order",
          (i < order.size()) ? order[i] : -1, i % 2);
    end

    // forced match on req1 frames: counter saturates
    do_reset();
    pat_mode = 1;
    bus.req1_valid = 1'b1;
    repeat (450) begin
      bus.req1_data = 1'($urandom);
      tick();
    end
    finish_frames();
    chk("sat_hit1", hit1_cnt, CMAX);
    chk("sat_hit0", hit0_cnt, 0);
    pat_mode = 0;

    // reset after 4 bits of a req1 frame
    do_reset();
    pat_mode = 1;
    bus.req1_valid = 1'b1;
    wait_accepts(4, 1'b1);
    tick();
    chk("mid_hit1_pre", hit1_cnt != 0, 1'b1);
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_grant", grant, 2'b00);
    chk("mid_busy", busy, 1'b0);
    chk("mid_det_rst", det_rst, 1'b1);
    chk("mid_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("mid_det_valid", det_valid, 1'b0);
    chk("mid_hit_pulse", hit_pulse, 2'b00);
    chk("mid_cnts", {hit1_cnt, hit0_cnt}, 0);
    pat_mode = 0;
    tick();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (busy) break;
      n++;
    end
    chk("mid_next_grant", grant, 2'b01);
    finish_frames();

    // owner goes quiet for 20 cycles mid-frame
    do_reset();
    bus.req0_valid = 1'b1;
    wait_accepts(4, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 16) chk("to_hold16", grant, 2'b01);
`ifdef ARB_TIMEOUT_EN
      if (i == 19) chk("to_grant19", grant, 2'b00);
`else
      if (i == 19) chk("to_grant19", grant, 2'b01);
`endif
    end
    bus.req0_valid = 1'b1;
    finish_frames();

    // randomized traffic with noise and resets
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) pat_mode = $urandom_range(0, 2);
      bus.req0_valid = ($urandom_range(0, 9) < 7);
      bus.req1_valid = ($urandom_range(0, 9) < 6);
      bus.req0_data = 1'($urandom);
      bus.req1_data = 1'($urandom);
      pat_rnd = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b1;
    pat_mode = 0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    finish_frames();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

endmodule
